count_sequence_checker: RTL and testbench
=========================================

COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the width of the monitored count.
REQ-002 The block SHALL have parameter LOCK_N, default 4, giving the number of consecutive in-sequence samples needed to lock (range 2..15).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; it is the only clock.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port clr  input  1  synchronous clear of lock state and error count.
REQ-006 The block SHALL have port valid  input  1  qualifies count on the current rising edge.
REQ-007 The block SHALL have port count  input  WIDTH  monitored up-counter value.
REQ-008 The block SHALL have port locked  output  1  high while state is LOCKED.
REQ-009 The block SHALL have port err  output  1  one-cycle pulse for a sequence break detected while locked or resyncing.
REQ-010 The block SHALL have port err_cnt  output  8  saturating count of err pulses.
REQ-011 The block SHALL have port expected  output  WIDTH  next value predicted for count.

Function
REQ-012 A sample SHALL be taken only on a rising edge with valid=1; with valid=0 all state, expected, match count and err_cnt SHALL hold, and err SHALL be 0.
REQ-013 "Match" SHALL mean count == expected; expected SHALL be computed modulo 2^WIDTH, so 3 -> 0 is a match at WIDTH=2.
REQ-014 The FSM SHALL have four states: UNLOCKED, ACQUIRE, LOCKED, RESYNC.
REQ-015 In UNLOCKED, a sample SHALL load expected=count+1 and match_cnt=1, and the next state SHALL be ACQUIRE.
REQ-016 In ACQUIRE, a match SHALL increment expected and match_cnt; when match_cnt reaches LOCK_N the next state SHALL be LOCKED.
REQ-017 In ACQUIRE, a mismatch SHALL reload expected=count+1 and match_cnt=1, stay in ACQUIRE, and not assert err.
REQ-018 In LOCKED, a match SHALL increment expected and keep the state LOCKED.
REQ-019 In LOCKED, a mismatch SHALL assert err, increment err_cnt, load expected=count+1, and go to RESYNC.
REQ-020 In RESYNC, a match SHALL increment expected and return to LOCKED with no err.
REQ-021 In RESYNC, a mismatch SHALL assert err, increment err_cnt, load expected=count+1, set match_cnt=1, and go to ACQUIRE.
REQ-022 All outputs SHALL be registered (Moore style): a sample on edge k SHALL be reflected in locked, err, err_cnt and expected during the cycle after edge k.
REQ-023 locked SHALL be decoded from the state register only.
REQ-024 err_cnt SHALL saturate at 255, and err SHALL still pulse while err_cnt is saturated.
REQ-025 clr=1 on an edge SHALL take priority over valid: state UNLOCKED, match_cnt=0, err_cnt=0, err=0, expected=0.
REQ-026 The default branch for an unreachable state encoding SHALL go to UNLOCKED.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force state UNLOCKED, locked=0, err=0, err_cnt=0, expected=0 and match_cnt=0.
REQ-028 After rst_n deasserts, the first valid sample SHALL be handled as an UNLOCKED sample.
REQ-029 Reset asserted mid-lock SHALL discard all lock history.

Structure
REQ-030 A shared package SHALL hold the state enum (2-bit encoding), the default WIDTH and LOCK_N, and ERR_CNT_MAX=255.
REQ-031 A single sub-module sat_counter (8-bit, saturating, with inc and sync clear) SHALL implement err_cnt.
REQ-032 The FSM and the expected/match_cnt datapath SHALL be in the top module.

Verification
REQ-033 Scenario: reset, then valid samples 0,1,2,3 -> locked=1 in the cycle after the 4th sample, expected=0, err never asserted.
REQ-034 Scenario: locked, then samples 0,2 -> single err pulse after sample 2, err_cnt=1, state RESYNC, expected=3; then sample 3 -> locked=1 again.
REQ-035 Scenario: locked, then samples 1,3 -> err pulses after sample 1 and again after sample 3, err_cnt=2, locked=0; then samples 0,1,2 -> locked=1.
REQ-036 Scenario: valid toggled 0/1 randomly during a 0..3 wrap sequence -> no err, and locked holds across the idle cycles.
REQ-037 Scenario: force 300 break events -> err_cnt=255, with err still pulsing; then clr=1 together with valid=1 -> err_cnt=0, locked=0.
REQ-038 Scenario: rst_n pulsed low between clock edges while locked -> locked=0 and err_cnt=0 before the next edge.

Source files
------------

// File: rtl/count_sequence_checker_pkg.sv
// count_sequence_checker_pkg
//   Shared definitions for the count sequence checker: the FSM state type,
//   default parameter values and the error-counter ceiling.
package count_sequence_checker_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_RESYNC   = 2'd3
  } state_t;

  localparam int          DEF_WIDTH   = 2;
  localparam int          DEF_LOCK_N  = 4;
  localparam int          ERR_CNT_W   = 8;
  localparam logic [7:0]  ERR_CNT_MAX = 8'd255;

  // match_cnt never exceeds LOCK_N, which is at most 15
  localparam int          MATCH_W     = 4;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// sat_counter
//   8-bit saturating event counter with synchronous clear.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (value -> 0)
//     clr    synchronous clear, has priority over inc
//     inc    count one event on this edge
//     value  current count, sticks at MAX
module sat_counter
  import count_sequence_checker_pkg::*;
#(
  parameter logic [7:0] MAX = ERR_CNT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != MAX)) begin
      value <= value + 8'd1;
    end
  end

endmodule

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
//   Watches a free-running up-counter and checks that successive valid
//   samples increment by one (modulo 2^WIDTH). After LOCK_N consecutive
//   in-sequence samples the checker locks; a break while locked gives one
//   chance to resync before falling back to acquisition.
//   Parameters:
//     WIDTH   width of the monitored count
//     LOCK_N  consecutive in-sequence samples needed to lock (2..15)
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     clr       synchronous clear of lock state and error count (beats valid)
//     valid     qualifies count on this edge
//     count     monitored counter value
//     locked    high while in LOCKED
//     err       one-cycle pulse for a break seen while LOCKED or RESYNC
//     err_cnt   saturating number of err pulses
//     expected  next value predicted for count
module count_sequence_checker
  import count_sequence_checker_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] expected
);

  state_t               state;
  logic [MATCH_W-1:0]   match_cnt;

  logic                 sample;
  logic                 hit;
  logic                 brk;
  logic                 reached;
  logic [WIDTH-1:0]     count_next;
  logic [WIDTH-1:0]     expected_next;

  always_comb begin
    sample        = valid && !clr;
    hit           = (count == expected);
    // a break only counts as an error once the checker has been locked
    brk           = sample && !hit &&
                    ((state == ST_LOCKED) || (state == ST_RESYNC));
    reached       = ((match_cnt + MATCH_W'(1)) == MATCH_W'(LOCK_N));
    count_next    = count + WIDTH'(1);
    expected_next = expected + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_UNLOCKED;
      expected  <= '0;
      match_cnt <= '0;
      err       <= 1'b0;
    end else if (clr) begin
      state     <= ST_UNLOCKED;
      expected  <= '0;
      match_cnt <= '0;
      err       <= 1'b0;
    end else begin
      err <= brk;
      if (valid) begin
        case (state)
          ST_UNLOCKED: begin
            expected  <= count_next;
            match_cnt <= MATCH_W'(1);
            state     <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (hit) begin
              expected  <= expected_next;
              match_cnt <= match_cnt + MATCH_W'(1);
              if (reached) begin
                state <= ST_LOCKED;
              end
            end else begin
              expected  <= count_next;
              match_cnt <= MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            if (hit) begin
              expected <= expected_next;
            end else begin
              expected <= count_next;
              state    <= ST_RESYNC;
            end
          end
          ST_RESYNC: begin
            if (hit) begin
              expected <= expected_next;
              state    <= ST_LOCKED;
            end else begin
              expected  <= count_next;
              match_cnt <= MATCH_W'(1);
              state     <= ST_ACQUIRE;
            end
          end
          default: begin
            state <= ST_UNLOCKED;
          end
        endcase
      end
    end
  end

  assign locked = (state == ST_LOCKED);

  sat_counter #(
    .MAX (ERR_CNT_MAX)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (brk),
    .value (err_cnt)
  );

endmodule

// File: tb/tb_count_sequence_checker.sv
module tb_count_sequence_checker;

  localparam int W  = 2;
  localparam int LN = 4;
  localparam int M  = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         valid;
  logic [W-1:0] count;
  logic         locked;
  logic         err;
  logic [7:0]   err_cnt;
  logic [W-1:0] expected;

  int total = 0;
  int bad   = 0;

  // reference model: a predictor with a run length and lock/resync flags
  bit tracking;
  bit m_locked;
  bit m_resync;
  int m_run;
  int m_exp;
  int m_errc;
  bit m_err;

  count_sequence_checker #(
    .WIDTH  (W),
    .LOCK_N (LN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .valid    (valid),
    .count    (count),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .expected (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", tag, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    tracking = 0;
    m_locked = 0;
    m_resync = 0;
    m_run    = 0;
    m_exp    = 0;
    m_errc   = 0;
    m_err    = 0;
  endfunction

  function automatic void model_edge(input bit v, input int c, input bit cl);
    m_err = 0;
    if (cl) begin
      model_reset();
    end else if (v) begin
      if (!tracking) begin
        tracking = 1;
        m_exp    = (c + 1) % M;
        m_run    = 1;
      end else if (c == m_exp) begin
        m_exp = (m_exp + 1) % M;
        if (m_resync) begin
          m_resync = 0;
          m_locked = 1;
        end else if (!m_locked) begin
          m_run++;
          if (m_run >= LN) m_locked = 1;
        end
      end else begin
        if (m_locked) begin
          m_err    = 1;
          m_locked = 0;
          m_resync = 1;
        end else if (m_resync) begin
          m_err    = 1;
          m_resync = 0;
          m_run    = 1;
        end else begin
          m_run = 1;
        end
        if (m_err && m_errc < 255) m_errc++;
        m_exp = (c + 1) % M;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".locked"},   32'(locked),   32'(m_locked));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".err_cnt"},  32'(err_cnt),  32'(m_errc));
    chk({tag, ".expected"}, 32'(expected), 32'(m_exp));
  endtask

  task automatic step(input string tag, input bit v, input int c, input bit cl);
    @(negedge clk);
    valid = v;
    count = W'(c);
    clr   = cl;
    @(posedge clk);
    model_edge(v, c % M, cl);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    valid = 1'b0;
    count = '0;
    model_reset();

    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // plain acquisition 0,1,2,3
    for (int i = 0; i < 4; i++) step("acq", 1, i, 0);
    chk("acq.lock_const", 32'(locked), 32'd1);
    chk("acq.exp_const", 32'(expected), 32'd0);

    // single break then recovery through RESYNC
    step("brk1a", 1, 0, 0);
    step("brk1b", 1, 2, 0);
    chk("brk1.err_const", 32'(err), 32'd1);
    chk("brk1.cnt_const", 32'(err_cnt), 32'd1);
    chk("brk1.exp_const", 32'(expected), 32'd3);
    step("brk1c", 1, 3, 0);
    chk("brk1.relock", 32'(locked), 32'd1);

    // clear, relock, then double break back to ACQUIRE
    step("clr1", 0, 0, 1);
    for (int i = 0; i < 4; i++) step("acq2", 1, i, 0);
    step("brk2a", 1, 1, 0);
    chk("brk2a.err_const", 32'(err), 32'd1);
    step("brk2b", 1, 3, 0);
    chk("brk2b.err_const", 32'(err), 32'd1);
    chk("brk2.cnt_const", 32'(err_cnt), 32'd2);
    chk("brk2.unlock", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) step("reacq", 1, i, 0);
    chk("reacq.lock_const", 32'(locked), 32'd1);

    // idle cycles interleaved with a wrapping sequence
    for (int i = 0; i < 40; i++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      step("idle", v, v ? m_exp : int'($urandom_range(0, M - 1)), 0);
      chk("idle.noerr", 32'(err), 32'd0);
      chk("idle.lock", 32'(locked), 32'd1);
    end

    // drive err_cnt into saturation
    for (int i = 0; i < 300; i++) begin
      step("sat_brk", 1, (m_exp + 2) % M, 0);
      chk("sat.pulse", 32'(err), 32'd1);
      step("sat_fix", 1, m_exp, 0);
    end
    chk("sat.cnt_const", 32'(err_cnt), 32'd255);
    step("sat_clr", 1, 1, 1);
    chk("satclr.cnt_const", 32'(err_cnt), 32'd0);
    chk("satclr.lock_const", 32'(locked), 32'd0);

    // asynchronous reset between edges while locked
    for (int i = 0; i < 4; i++) step("acq3", 1, i, 0);
    step("ar_brk", 1, 2, 0);
    step("ar_fix", 1, m_exp, 0);
    chk("ar.pre_lock", 32'(locked), 32'd1);
    chk("ar.pre_cnt", 32'(err_cnt), 32'd1);
    @(negedge clk);
    valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.lock", 32'(locked), 32'd0);
    chk("ar.cnt", 32'(err_cnt), 32'd0);
    check_all("ar");
    #1 rst_n = 1'b1;
    step("ar_first", 1, 2, 0);
    chk("ar_first.exp_const", 32'(expected), 32'd3);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit v;
      bit cl;
      int c;
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 3) != 0) ? m_exp : int'($urandom_range(0, M - 1));
      step("rnd", v, c, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
